// File: rtl/gpio_in_pkg.sv
// Shared defaults and helpers for the GPIO input debouncer.
package gpio_in_pkg;

    localparam int unsigned GPIO_TICK_DIV_DEFAULT     = 100000;
    localparam int unsigned GPIO_STABLE_TICKS_DEFAULT = 8;

    // Counter width able to hold 0..stable_ticks.
    function automatic int unsigned cnt_width(input int unsigned stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch line: 2-flop synchroniser, tick-qualified stability counter
// and registered rise/fall pulses.
module debounce_bit
    import gpio_in_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = GPIO_STABLE_TICKS_DEFAULT
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic raw_i,
    input  logic tick_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned    CW   = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= raw_i;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any agreement restarts the count, so only an unbroken run of mismatching ticks is accepted.
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (tick_i) begin
                if (r_cnt == LAST) begin
                    r_db   <= r_sync;
                    r_cnt  <= '0;
                    r_rise <= r_sync;
                    r_fall <= ~r_sync;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign db_o   = r_db;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounced GPIO input block: shared tick prescaler, WIDTH debounce_bit lines,
// change strobe and optional sticky IRQ (enabled by GPIO_DEBOUNCE_IRQ_EN).
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned TICK_DIV     = GPIO_TICK_DIV_DEFAULT,
    parameter int unsigned STABLE_TICKS = GPIO_STABLE_TICKS_DEFAULT
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] db_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o,
    output logic             irq_o,
    input  logic             irq_clr_i
);

    localparam int unsigned TW = $clog2(TICK_DIV);

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk_i  (clk_i),
            .arst_i (arst_i),
            .raw_i  (raw_i[g]),
            .tick_i (w_tick),
            .db_o   (db_o[g]),
            .rise_o (rise_o[g]),
            .fall_o (fall_o[g])
        );
    end

    assign changed_o = |(rise_o | fall_o);

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic r_irq;

    // Set has priority so a change coinciding with a clear is never lost.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_irq <= 1'b0;
        end else if (changed_o) begin
            r_irq <= 1'b1;
        end else if (irq_clr_i) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`else
    logic w_unused_irq_clr;

    assign w_unused_irq_clr = irq_clr_i;
    assign irq_o            = 1'b0;
`endif

endmodule
